// File: rtl/quad_pkg.sv
// Shared quadrature definitions: phase ring encoding (AB) and ring stepping, so the
// generator and the quad decoder agree on which direction is forward.
package quad_pkg;

    localparam int unsigned MIN_PERIOD_DEFAULT = 4;

    typedef enum logic [1:0] {
        S00 = 2'b00,
        S01 = 2'b01,
        S10 = 2'b10,
        S11 = 2'b11
    } phase_t;

    // Forward ring: S00 -> S10 -> S11 -> S01 -> S00
    function automatic phase_t phase_fwd(input phase_t s);
        phase_t n;
        unique case (s)
            S00:     n = S10;
            S10:     n = S11;
            S11:     n = S01;
            default: n = S00;
        endcase
        return n;
    endfunction

    function automatic phase_t phase_rev(input phase_t s);
        phase_t n;
        unique case (s)
            S00:     n = S01;
            S01:     n = S11;
            S11:     n = S10;
            default: n = S00;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/quad_period_timer.sv
// Edge-interval timer: clamps commanded periods, holds active/shadow command sets and
// emits one step pulse per quadrature edge with the direction of that edge.
module quad_period_timer
    import quad_pkg::*;
#(
    parameter int unsigned PER_W      = 16,
    parameter int unsigned MIN_PERIOD = MIN_PERIOD_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PER_W-1:0] i_period,
    input  logic             i_dir,
    input  logic             i_load,
    output logic             step,
    output logic             step_dir,
    output logic             running
);

    logic [PER_W-1:0] act_per_q, act_per_d;
    logic             act_dir_q, act_dir_d;
    logic [PER_W-1:0] pend_per_q, pend_per_d;
    logic             pend_dir_q, pend_dir_d;
    logic             pend_vld_q, pend_vld_d;
    logic [PER_W-1:0] timer_q, timer_d;
    logic             run_q, run_d;
    logic [PER_W-1:0] load_per;
    logic [PER_W-1:0] next_per;
    logic             next_dir;

    function automatic logic [PER_W-1:0] clamp(input logic [PER_W-1:0] p);
        if (p == '0) begin
            return '0;
        end else if (p < PER_W'(MIN_PERIOD)) begin
            return PER_W'(MIN_PERIOD);
        end
        return p;
    endfunction

    always_comb begin
        load_per   = clamp(i_period);
        step       = run_q && (timer_q == PER_W'(1));
        act_per_d  = act_per_q;
        act_dir_d  = act_dir_q;
        pend_per_d = pend_per_q;
        pend_dir_d = pend_dir_q;
        pend_vld_d = pend_vld_q;
        timer_d    = timer_q;
        run_d      = run_q;
        next_per   = act_per_q;
        next_dir   = act_dir_q;

        if (!run_q) begin
            if (i_load && (load_per != '0)) begin
                act_per_d = load_per;
                act_dir_d = i_dir;
                timer_d   = load_per;
                run_d     = 1'b1;
            end
        end else if (step) begin
            // A load landing on the edge itself is the newest shadow value, so it wins.
            if (i_load) begin
                next_per = load_per;
                next_dir = i_dir;
            end else if (pend_vld_q) begin
                next_per = pend_per_q;
                next_dir = pend_dir_q;
            end
            act_per_d  = next_per;
            act_dir_d  = next_dir;
            pend_per_d = next_per;
            pend_dir_d = next_dir;
            pend_vld_d = 1'b0;
            timer_d    = next_per;
            run_d      = (next_per != '0);
        end else begin
            timer_d = timer_q - PER_W'(1);
            if (i_load) begin
                pend_per_d = load_per;
                pend_dir_d = i_dir;
                pend_vld_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_per_q  <= '0;
            act_dir_q  <= 1'b1;
            pend_per_q <= '0;
            pend_dir_q <= 1'b1;
            pend_vld_q <= 1'b0;
            timer_q    <= '0;
            run_q      <= 1'b0;
        end else begin
            act_per_q  <= act_per_d;
            act_dir_q  <= act_dir_d;
            pend_per_q <= pend_per_d;
            pend_dir_q <= pend_dir_d;
            pend_vld_q <= pend_vld_d;
            timer_q    <= timer_d;
            run_q      <= run_d;
        end
    end

    assign step_dir = act_dir_q;
    assign running  = run_q;

endmodule

// File: rtl/quad_gen.sv
// Quadrature encoder emulator: phase FSM and signed position counter driven by the
// period timer's step pulse; A/B, count and edge strobe all update on the same clock.
module quad_gen
    import quad_pkg::*;
#(
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned PER_W      = 16,
    parameter int unsigned MIN_PERIOD = MIN_PERIOD_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PER_W-1:0] i_period,
    input  logic             i_dir,
    input  logic             i_load,
    input  logic             i_clr,
    output logic             quadA,
    output logic             quadB,
    output logic [CNT_W-1:0] o_count,
    output logic             o_edge,
    output logic             o_running
);

    logic             step;
    logic             step_dir;
    phase_t           phase_q, phase_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             edge_q;

    quad_period_timer #(
        .PER_W      (PER_W),
        .MIN_PERIOD (MIN_PERIOD)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .i_period (i_period),
        .i_dir    (i_dir),
        .i_load   (i_load),
        .step     (step),
        .step_dir (step_dir),
        .running  (o_running)
    );

    always_comb begin
        phase_d = phase_q;
        cnt_d   = cnt_q;
        if (step) begin
            phase_d = step_dir ? phase_fwd(phase_q) : phase_rev(phase_q);
            cnt_d   = step_dir ? cnt_q + CNT_W'(1) : cnt_q - CNT_W'(1);
        end
        // Clear overrides a coincident edge's count update only; the phase still advances.
        if (i_clr) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q <= S00;
            cnt_q   <= '0;
            edge_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            edge_q  <= step;
        end
    end

    assign quadA   = phase_q[1];
    assign quadB   = phase_q[0];
    assign o_count = cnt_q;
    assign o_edge  = edge_q;

endmodule

// File: tb/tb_quad_gen.sv
// Self-checking bench for quad_gen: a scoreboard of expected edges (cycle, AB, count)
// filled by each scenario task and drained by a monitor on o_edge, plus a decoder model.
module tb_quad_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] i_period = '0;
    logic        i_dir = 1'b1;
    logic        i_load = 1'b0;
    logic        i_clr = 1'b0;
    logic        quadA, quadB;
    logic [15:0] o_count;
    logic        o_edge, o_running;

    quad_gen #(
        .CNT_W      (16),
        .PER_W      (16),
        .MIN_PERIOD (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_period  (i_period),
        .i_dir     (i_dir),
        .i_load    (i_load),
        .i_clr     (i_clr),
        .quadA     (quadA),
        .quadB     (quadB),
        .o_count   (o_count),
        .o_edge    (o_edge),
        .o_running (o_running)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [1:0]  ab;
        logic [15:0] cnt;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    int          n_edges = 0;
    logic [1:0]  m_ab = 2'b00;
    logic [15:0] m_cnt = '0;
    logic [1:0]  dec_prev = 2'b00;
    int          dec_count = 0;
    int          dec_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [1:0] m_fwd(input logic [1:0] s);
        case (s)
            2'b00:   return 2'b10;
            2'b10:   return 2'b11;
            2'b11:   return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [1:0] m_rev(input logic [1:0] s);
        case (s)
            2'b00:   return 2'b01;
            2'b01:   return 2'b11;
            2'b11:   return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!rst && o_edge) begin
            exp_t e;
            n_edges++;
            n_checks++;
            if (sb.size() == 0) begin
                $display("FAIL unexpected_edge cyc=%0d ab=%b count=%h", cyc, {quadA, quadB},
                         o_count);
            end else begin
                e = sb.pop_front();
                if (cyc !== e.cyc || {quadA, quadB} !== e.ab || o_count !== e.cnt)
                    $display("FAIL edge got cyc=%0d ab=%b count=%h want cyc=%0d ab=%b count=%h",
                             cyc, {quadA, quadB}, o_count, e.cyc, e.ab, e.cnt);
                else
                    n_pass++;
            end
        end
    end

    // Independent decoder model for the loopback scenario
    always @(negedge clk) begin
        if (rst) begin
            dec_prev  = 2'b00;
            dec_count = 0;
        end else if ({quadA, quadB} != dec_prev) begin
            if ({quadA, quadB} == m_fwd(dec_prev)) dec_count++;
            else if ({quadA, quadB} == m_rev(dec_prev)) dec_count--;
            else dec_bad++;
            dec_prev = {quadA, quadB};
        end
    end

    task automatic push_edges(input int start, input int per, input bit dir, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            m_ab    = dir ? m_fwd(m_ab) : m_rev(m_ab);
            m_cnt   = dir ? m_cnt + 16'd1 : m_cnt - 16'd1;
            e.cyc   = start + i * per;
            e.ab    = m_ab;
            e.cnt   = m_cnt;
            sb.push_back(e);
        end
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called #1 after a posedge; returns the cycle whose edge sampled the load.
    task automatic do_load(input int p, input bit d, output int l);
        i_period = 16'(p);
        i_dir    = d;
        i_load   = 1'b1;
        @(posedge clk);
        #1;
        i_load = 1'b0;
        l = cyc;
    endtask

    task automatic check_drained(input string name);
        n_checks++;
        if (sb.size() != 0) $display("FAIL %s_missing_edges left=%0d want 0", name, sb.size());
        else n_pass++;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks += 5;
        if (quadA !== 1'b0) $display("FAIL rst_quadA got %b want 0", quadA); else n_pass++;
        if (quadB !== 1'b0) $display("FAIL rst_quadB got %b want 0", quadB); else n_pass++;
        if (o_count !== 16'h0) $display("FAIL rst_count got %h want 0", o_count); else n_pass++;
        if (o_edge !== 1'b0) $display("FAIL rst_edge got %b want 0", o_edge); else n_pass++;
        if (o_running !== 1'b0) $display("FAIL rst_running got %b want 0", o_running);
        else n_pass++;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_forward;
        int l, l2;
        do_load(5, 1'b1, l);
        push_edges(l + 5, 5, 1'b1, 4);
        n_checks++;
        if (o_running !== 1'b1) $display("FAIL fwd_running_rise got %b want 1", o_running);
        else n_pass++;
        wait_to(l + 16);
        do_load(0, 1'b1, l2);
        wait_to(l + 21);
        n_checks++;
        if (o_running !== 1'b0) $display("FAIL fwd_running_fall got %b want 0", o_running);
        else n_pass++;
        check_drained("fwd");
    endtask

    task automatic test_reverse_on_fly;
        int l, l2;
        do_load(5, 1'b1, l);
        push_edges(l + 5, 5, 1'b1, 3);
        push_edges(l + 20, 5, 1'b0, 2);
        wait_to(l + 11);
        n_checks++;
        if ({quadA, quadB} !== 2'b11) $display("FAIL rev_pre_state got %b want 11", {quadA, quadB});
        else n_pass++;
        do_load(5, 1'b0, l2);
        wait_to(l + 21);
        do_load(0, 1'b0, l2);
        wait_to(l + 27);
        n_checks++;
        if (o_running !== 1'b0) $display("FAIL rev_halt got %b want 0", o_running); else n_pass++;
        check_drained("rev");
    endtask

    task automatic test_clamp_stop;
        int l, l2, e0;
        do_load(2, 1'b1, l);
        push_edges(l + 4, 4, 1'b1, 3);
        wait_to(l + 8);
        do_load(0, 1'b1, l2);
        wait_to(l + 13);
        n_checks++;
        if (o_running !== 1'b0) $display("FAIL clamp_halt got %b want 0", o_running);
        else n_pass++;
        e0 = n_edges;
        wait_to(l + 63);
        n_checks += 2;
        if ({quadA, quadB} !== m_ab)
            $display("FAIL clamp_hold_ab got %b want %b", {quadA, quadB}, m_ab);
        else n_pass++;
        if (n_edges !== e0) $display("FAIL clamp_idle_edges got %0d want %0d", n_edges, e0);
        else n_pass++;
        check_drained("clamp");
    endtask

    task automatic test_wrap_clear;
        int   l, l2;
        exp_t e;
        i_clr = 1'b1;
        @(posedge clk);
        #1;
        i_clr = 1'b0;
        m_cnt = '0;
        n_checks++;
        if (o_count !== 16'h0) $display("FAIL clr_idle got %h want 0000", o_count); else n_pass++;
        do_load(4, 1'b0, l);
        push_edges(l + 4, 4, 1'b0, 1);
        m_ab  = m_rev(m_ab);
        m_cnt = '0;
        e.cyc = l + 8;
        e.ab  = m_ab;
        e.cnt = m_cnt;
        sb.push_back(e);
        push_edges(l + 12, 4, 1'b0, 1);
        wait_to(l + 5);
        n_checks++;
        if (o_count !== 16'hFFFF) $display("FAIL wrap_under got %h want ffff", o_count);
        else n_pass++;
        wait_to(l + 7);
        i_clr = 1'b1;
        @(posedge clk);
        #1;
        i_clr = 1'b0;
        do_load(0, 1'b0, l2);
        n_checks += 2;
        if (o_count !== 16'h0) $display("FAIL clr_on_edge got %h want 0000", o_count);
        else n_pass++;
        if ({quadA, quadB} !== 2'b11)
            $display("FAIL clr_edge_ab got %b want 11", {quadA, quadB});
        else n_pass++;
        wait_to(l + 14);
        check_drained("wrap");
    endtask

    task automatic test_reset_mid;
        int l, l2, e0;
        do_load(8, 1'b1, l);
        do_load(3, 1'b0, l2);
        wait_to(l + 2);
        #1;
        rst = 1'b1;
        #1;
        n_checks += 5;
        if (quadA !== 1'b0) $display("FAIL mid_rst_quadA got %b want 0", quadA); else n_pass++;
        if (quadB !== 1'b0) $display("FAIL mid_rst_quadB got %b want 0", quadB); else n_pass++;
        if (o_count !== 16'h0) $display("FAIL mid_rst_count got %h want 0", o_count);
        else n_pass++;
        if (o_edge !== 1'b0) $display("FAIL mid_rst_edge got %b want 0", o_edge); else n_pass++;
        if (o_running !== 1'b0) $display("FAIL mid_rst_running got %b want 0", o_running);
        else n_pass++;
        m_ab  = 2'b00;
        m_cnt = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        e0 = n_edges;
        repeat (30) @(posedge clk);
        #1;
        n_checks += 2;
        if (n_edges !== e0) $display("FAIL post_rst_edges got %0d want %0d", n_edges, e0);
        else n_pass++;
        if (o_running !== 1'b0) $display("FAIL post_rst_running got %b want 0", o_running);
        else n_pass++;
    endtask

    task automatic test_loopback;
        int l, l2;
        do_load(6, 1'b1, l);
        push_edges(l + 6, 6, 1'b1, 100);
        wait_to(l + 596);
        do_load(6, 1'b0, l2);
        push_edges(l + 606, 6, 1'b0, 40);
        wait_to(l + 835);
        do_load(0, 1'b1, l2);
        wait_to(l + 842);
        n_checks += 4;
        if (dec_count !== 60) $display("FAIL loop_dec_count got %0d want 60", dec_count);
        else n_pass++;
        if (o_count !== 16'd60) $display("FAIL loop_count got %0d want 60", o_count);
        else n_pass++;
        if (dec_bad !== 0) $display("FAIL loop_illegal_steps got %0d want 0", dec_bad);
        else n_pass++;
        if (o_running !== 1'b0) $display("FAIL loop_halt got %b want 0", o_running);
        else n_pass++;
        check_drained("loop");
    endtask

    initial begin
        test_reset;
        test_forward;
        test_reverse_on_fly;
        test_clamp_stop;
        test_wrap_clear;
        test_reset_mid;
        test_loopback;
        repeat (5) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/quad_gen.md
# quad_gen

Quadrature encoder emulator: converts a commanded edge period and direction into `quadA`/`quadB` phase outputs plus a matching signed position count. It is the transmit-side counterpart of the `quad` decoder. It drives the decoder (and `o_velocity`) in-system for closed-loop bring-up of the velocity S-curve path without a physical encoder. Its count output must track the decoder's `count` edge-for-edge.

## Interface
- `CNT_W`, 16, width of `o_count` (two's complement, wraps).
- `PER_W`, 16, width of the period command.
- `MIN_PERIOD`, 4, minimum clocks between A/B transitions; nonzero commands below this are clamped up.

Ports:
- `clk` in 1: single system clock, all logic rising-edge.
- `rst` in 1: reset, asynchronous and active-high.
- `i_period` in PER_W: clocks per quadrature edge; 0 = stop.
- `i_dir` in 1: 1 = forward, 0 = reverse.
- `i_load` in 1: one-cycle strobe; samples `i_period`/`i_dir`.
- `i_clr` in 1: synchronous clear of `o_count`.
- `quadA`, `quadB` out 1: registered phase outputs.
- `o_count` out CNT_W: position, +1 per forward edge, −1 per reverse edge.
- `o_edge` out 1: one-cycle pulse in the cycle A/B change.
- `o_running` out 1: high while an active nonzero period is in force.

## Operation
- Phase FSM states, encoded as AB: S00 → S10 → S11 → S01 → S00 forward. Reverse traverses the same ring backwards. Exactly one of A/B changes per edge.
- Registers:
  - Active set: `act_per`, `act_dir`.
  - Shadow set: `pend_per`, `pend_dir`, `pend_vld`.
  - Down-counter `timer`.
- `i_load` while stopped (`o_running`=0):
  - The command becomes active immediately and `timer` loads the clamped period.
  - The first edge occurs P cycles after the load edge.
  - Loading 0 while stopped is a no-op.
- `i_load` while running:
  - Writes the shadow set and sets `pend_vld`.
  - The interval in progress completes at the old period and direction.
  - At that edge the shadow set is promoted and the next interval uses the new values.
  - A second `i_load` before promotion overwrites the shadow; last one wins.
- Promoted period 0: the completing edge still occurs, then the block halts. `o_running`=0 and A/B hold their state.
- Direction change: takes effect at the promotion edge as a single step backwards along the ring. No skipped or doubled states.
- Clamp: nonzero P < MIN_PERIOD is replaced by MIN_PERIOD. P ≥ MIN_PERIOD is used as-is.
- Count: modulo 2^CNT_W. 0x7FFF+1 → 0x8000; 0x0000−1 → 0xFFFF.
- `i_clr` in the same cycle as an edge: clear wins and `o_count`=0. A/B still advance and `o_edge` still pulses.

## Timing
- Reset values:
  - `quadA`=0, `quadB`=0 (S00).
  - `o_count`=0, `o_edge`=0, `o_running`=0.
  - `timer`=0, `pend_vld`=0, active/shadow period 0, dir 1.
- Edge spacing is exactly `act_per` clocks. A/B, `o_count` and `o_edge` all update on the same rising edge; there is no skew between them.
- Load-to-first-edge latency (stopped): P cycles.
- `o_running` rises the cycle after the load and falls the cycle after the halting edge.
- Reset asserted mid-interval: everything returns to reset values asynchronously and the pending command is discarded.
- After reset release, the block stays idle until the next `i_load`.

## Structure
- Package `quad_pkg`:
  - Phase state typedef/localparams S00, S10, S11, S01.
  - Next-state functions for forward and reverse.
  - `MIN_PERIOD` default.
  - Shared with `quad` so decoder and generator agree on forward direction.
- One sub-module, `quad_period_timer`:
  - Holds the down-counter, clamp, and active/shadow promotion.
  - Emits a single `step` pulse to the top level.
  - The top level holds the phase FSM and position counter.

## Test plan
- **Forward run:** reset, then `i_load` with P=5, dir=1.
  - AB sequence is 10, 11, 01, 00 at edges spaced 5 clocks apart.
  - First change occurs 5 cycles after load.
  - `o_count` reads 1, 2, 3, 4 and `o_edge` pulses 4 times.
- **Reverse on the fly:** while running P=5, dir=1 in state S11, load dir=0.
  - The current interval completes (→ S01, count +1).
  - The next edge returns to S11 and count −1. No state is skipped.
- **Clamp and stop:** load P=2.
  - Edges are spaced 4 clocks apart.
  - Then load P=0: exactly one more edge occurs, `o_running` drops, and AB holds for 50 cycles.
- **Wrap and clear:** preset by running reverse from 0.
  - One reverse edge gives `o_count`=0xFFFF.
  - Assert `i_clr` coincident with an edge: `o_count`=0 and A/B still advance.
- **Reset mid-interval:** assert `rst` 2 cycles into a P=8 interval with a pending load.
  - All outputs read 0 immediately.
  - No edges occur after release until a new `i_load`.
- **Loopback:** connect to `quad`, then run 100 forward and 40 reverse edges at P=6.
  - Decoder `count` equals `o_count` = 60.
